// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and types for the LCD write-bus receiver
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAM_HI,
    ST_RAM_LO
  } lcd_rx_state_t;

  typedef struct packed {
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
  } window_t;

  function automatic window_t default_window(input logic [15:0] col_end,
                                             input logic [15:0] row_end);
    window_t w;
    w.xs = 16'd0;
    w.xe = col_end;
    w.ys = 16'd0;
    w.ye = row_end;
    return w;
  endfunction

endpackage

// File: rtl/lcd_addr_ctr.sv
// rtl/lcd_addr_ctr.sv - pixel pointer that walks the address window in raster order
module lcd_addr_ctr
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  window_t     win,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        wrap
);

  logic x_wrap;
  logic y_wrap;

  // Using >= rather than == lets a degenerate window (start > end) pin the
  // coordinate at its start value on every step.
  assign x_wrap = (x >= win.xe);
  assign y_wrap = (y >= win.ye);
  assign wrap   = x_wrap & y_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= 16'd0;
      y <= 16'd0;
    end else if (load) begin
      x <= win.xs;
      y <= win.ys;
    end else if (step) begin
      if (!x_wrap) begin
        x <= x + 16'd1;
      end else begin
        x <= win.xs;
        y <= y_wrap ? win.ys : (y + 16'd1);
      end
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - decodes 8080-style LCD writes into commands and RGB565 pixel strobes
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter logic [15:0] COL_END = 16'd239,
  parameter logic [15:0] ROW_END = 16'd319
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        frame_done,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_code
);

  lcd_rx_state_t state;
  window_t       win;
  logic          wr_q;
  logic [1:0]    idx;
  logic [23:0]   shadow;
  logic [7:0]    hi_byte;
  logic          capture;
  logic          ptr_load;
  logic          ptr_step;
  logic          ptr_wrap;
  logic [15:0]   ptr_x;
  logic [15:0]   ptr_y;

  assign capture  = wr & ~wr_q & ~sync;
  assign ptr_load = capture & ~dcx & (D == CMD_RAMWR);
  assign ptr_step = capture & dcx & (state == ST_RAM_LO);

  lcd_addr_ctr u_addr_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ptr_load),
    .step  (ptr_step),
    .win   (win),
    .x     (ptr_x),
    .y     (ptr_y),
    .wrap  (ptr_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      win        <= default_window(COL_END, ROW_END);
      wr_q       <= 1'b1;
      idx        <= 2'd0;
      shadow     <= 24'd0;
      hi_byte    <= 8'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 16'd0;
      pix_y      <= 16'd0;
      pix_color  <= 16'd0;
      frame_done <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_code   <= 8'd0;
    end else begin
      wr_q       <= wr;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      cmd_strobe <= 1'b0;

      if (sync) begin
        // Deselect drops any partial parameter set or half pixel.
        state <= ST_IDLE;
        idx   <= 2'd0;
      end else if (capture && !dcx) begin
        cmd_strobe <= 1'b1;
        cmd_code   <= D;
        idx        <= 2'd0;
        case (D)
          CMD_CASET: state <= ST_CASET;
          CMD_PASET: state <= ST_PASET;
          CMD_RAMWR: state <= ST_RAM_HI;
          CMD_SWRESET: begin
            state <= ST_IDLE;
            win   <= default_window(COL_END, ROW_END);
          end
          default: state <= ST_IDLE;
        endcase
      end else if (capture) begin
        case (state)
          ST_CASET, ST_PASET: begin
            if (idx == 2'd3) begin
              // Shadow holds start_hi, start_lo, end_hi; commit all four at once.
              if (state == ST_CASET) begin
                win.xs <= shadow[23:8];
                win.xe <= {shadow[7:0], D};
              end else begin
                win.ys <= shadow[23:8];
                win.ye <= {shadow[7:0], D};
              end
              state <= ST_IDLE;
              idx   <= 2'd0;
            end else begin
              shadow <= {shadow[15:0], D};
              idx    <= idx + 2'd1;
            end
          end
          ST_RAM_HI: begin
            hi_byte <= D;
            state   <= ST_RAM_LO;
          end
          ST_RAM_LO: begin
            pix_valid  <= 1'b1;
            pix_x      <= ptr_x;
            pix_y      <= ptr_y;
            pix_color  <= {hi_byte, D};
            frame_done <= ptr_wrap;
            state      <= ST_RAM_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

  typedef struct packed {
    logic        fd;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] c;
  } pix_t;

  logic        clk;
  logic        reset;
  logic        sync;
  logic        wr;
  logic        dcx;
  logic [7:0]  D;
  logic        pix_valid;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic [15:0] pix_color;
  logic        frame_done;
  logic        cmd_strobe;
  logic [7:0]  cmd_code;

  int   errors = 0;
  int   checks = 0;
  int   cmd_seen = 0;
  pix_t obs_q[$];
  pix_t exp_q[$];
  int   m_xs, m_xe, m_ys, m_ye;

  lcd_bus_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .wr         (wr),
    .dcx        (dcx),
    .D          (D),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .frame_done (frame_done),
    .cmd_strobe (cmd_strobe),
    .cmd_code   (cmd_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    pix_t p;
    if (pix_valid) begin
      p.fd = frame_done;
      p.x  = pix_x;
      p.y  = pix_y;
      p.c  = pix_color;
      obs_q.push_back(p);
    end
    if (cmd_strobe) cmd_seen++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus write at full rate: wr low for a cycle, then high; capture lands on the next edge.
  task automatic send(input logic d_c, input logic [7:0] b);
    @(posedge clk); #1;
    wr = 1'b0; dcx = d_c; D = b;
    @(posedge clk); #1;
    wr = 1'b1;
  endtask

  task automatic do_swreset();
    send(1'b0, 8'h01);
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
  endtask

  task automatic do_caset(input int s, input int e);
    send(1'b0, 8'h2A);
    send(1'b1, s[15:8]); send(1'b1, s[7:0]);
    send(1'b1, e[15:8]); send(1'b1, e[7:0]);
    m_xs = s; m_xe = e;
  endtask

  task automatic do_paset(input int s, input int e);
    send(1'b0, 8'h2B);
    send(1'b1, s[15:8]); send(1'b1, s[7:0]);
    send(1'b1, e[15:8]); send(1'b1, e[7:0]);
    m_ys = s; m_ye = e;
  endtask

  // Reference: the k-th pixel of a RAMWR sits at raster offset k modulo the window area.
  task automatic do_ramwr(input int n);
    pix_t p;
    int w, h, col, row;
    logic [15:0] c;
    send(1'b0, 8'h2C);
    w = (m_xs <= m_xe) ? (m_xe - m_xs + 1) : 1;
    h = (m_ys <= m_ye) ? (m_ye - m_ys + 1) : 1;
    for (int k = 0; k < n; k++) begin
      c   = 16'($urandom);
      col = k % w;
      row = (k / w) % h;
      p.x  = 16'(m_xs + col);
      p.y  = 16'(m_ys + row);
      p.c  = c;
      p.fd = (col == w - 1) && (row == h - 1);
      exp_q.push_back(p);
      send(1'b1, c[15:8]);
      send(1'b1, c[7:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sync = 1'b0; wr = 1'b1; dcx = 1'b0; D = 8'h2A;
    idle(2);
    wr = 1'b0;
    idle(1);
    wr = 1'b1;
    idle(2);
    checks++;
    if ({pix_valid, frame_done, cmd_strobe} !== 3'b000) begin
      errors++; $display("FAIL reset strobes: got %b expected 000", {pix_valid, frame_done, cmd_strobe});
    end
    checks++;
    if ({pix_x, pix_y, pix_color, cmd_code} !== 56'd0) begin
      errors++; $display("FAIL reset outputs: got x=%0d y=%0d c=%h cmd=%h expected zeros", pix_x, pix_y, pix_color, cmd_code);
    end
    reset = 1'b0;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
    idle(4);
    checks++;
    if (cmd_seen !== 0) begin
      errors++; $display("FAIL reset wr held high: got %0d cmd strobes expected 0", cmd_seen);
    end
    dcx = 1'b1;
  endtask

  task automatic test_basic();
    pix_t e, o;
    int c0;
    c0 = cmd_seen;
    exp_q.push_back({1'b0, 16'd0, 16'd0, 16'hF800});
    exp_q.push_back({1'b0, 16'd1, 16'd0, 16'h07E0});
    send(1'b0, 8'h2C);
    send(1'b1, 8'hF8); send(1'b1, 8'h00);
    send(1'b1, 8'h07); send(1'b1, 8'hE0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_color !== 16'h07E0) begin
      errors++; $display("FAIL basic latency: got valid=%b c=%h expected valid=1 c=07e0", pix_valid, pix_color);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL basic pulse width: got valid=%b expected 0", pix_valid);
    end
    idle(3);
    checks++;
    if (cmd_seen - c0 !== 1 || cmd_code !== 8'h2C) begin
      errors++; $display("FAIL basic cmd: got strobes=%0d code=%h expected 1, 2c", cmd_seen - c0, cmd_code);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic count: got %0d pixels expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL basic pixel: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_window();
    pix_t e, o;
    do_caset(5, 6);
    do_paset(2, 3);
    do_ramwr(5);
    idle(4);
    checks++;
    if (obs_q.size() !== 5) begin
      errors++; $display("FAIL window count: got %0d pixels expected 5", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL window pixel: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_partial_caset();
    pix_t e, o;
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); send(1'b1, 8'h09); send(1'b1, 8'h00);
    do_ramwr(3);
    idle(4);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL partial count: got %0d pixels expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL partial pixel: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_deselect();
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    idle(1);
    sync = 1'b1;
    idle(2);
    sync = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i * 37));
    idle(4);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL deselect: got %0d pixels expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_sync_ignore();
    pix_t e, o;
    int c0;
    c0 = cmd_seen;
    sync = 1'b1;
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); send(1'b1, 8'h01);
    idle(2);
    sync = 1'b0;
    idle(2);
    checks++;
    if (cmd_seen !== c0 || cmd_code !== 8'h2C) begin
      errors++; $display("FAIL sync ignore: got strobes=%0d code=%h expected 0, 2c", cmd_seen - c0, cmd_code);
    end
    do_ramwr(2);
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL sync ignore pixel: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
      end
    end
    checks++;
    if (exp_q.size() !== obs_q.size()) begin
      errors++; $display("FAIL sync ignore count: got %0d leftover expected %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_degenerate();
    pix_t e, o;
    do_swreset();
    idle(2);
    checks++;
    if (cmd_code !== 8'h01) begin
      errors++; $display("FAIL swreset code: got %h expected 01", cmd_code);
    end
    do_caset(10, 4);
    do_ramwr(3);
    idle(4);
    checks++;
    if (obs_q.size() !== 3) begin
      errors++; $display("FAIL degenerate count: got %0d pixels expected 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL degenerate pixel: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    pix_t e, o;
    int xs, ys;
    for (int it = 0; it < 8; it++) begin
      xs = (it == 0) ? 65533 : int'($urandom_range(0, 6));
      ys = (it == 1) ? 65534 : int'($urandom_range(0, 6));
      do_caset(xs, (it == 0) ? 65535 : int'($urandom_range(0, 6)));
      do_paset(ys, (it == 1) ? 65535 : int'($urandom_range(0, 6)));
      do_ramwr(int'($urandom_range(1, 24)));
      idle(4);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL random count it=%0d: got %0d pixels expected %0d", it, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin
          errors++; $display("FAIL random pixel it=%0d: got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", it, o.x, o.y, o.c, o.fd, e.x, e.y, e.c, e.fd);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window();
    test_partial_caset();
    test_deselect();
    test_sync_ignore();
    test_degenerate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
